// File: rtl/full_adder.sv
// Full adder cell with a registered copy and an LSB-first bit-serial WIDTH-bit adder.
// Latency: sum/carry 0 cycles, registered copy 1 cycle, serial word WIDTH enabled cycles; no backpressure (en_i stalls).
module full_adder #(
    parameter int WIDTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o,
    input  logic en_i,
    input  logic ser_clr_i,
    output logic s_q_o,
    output logic c_q_o,
    output logic ser_s_o,
    output logic ser_c_o,
    output logic ser_done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic          sum_q,   sum_d;
    logic          cout_q,  cout_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          ser_c_q, ser_c_d;
    logic          done_q,  done_d;
    logic          ser_maj;

    always_comb begin
        {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {1'b0, c_i};
    end

    assign ser_s_o = a_i ^ b_i ^ carry_q;
    assign ser_maj = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        ser_c_d = ser_c_q;
        done_d  = 1'b0;

        if (en_i) begin
            sum_d  = s_o;
            cout_d = c_o;
        end

        // Clear wins over enable and consumes no bit; the last word's carry is kept.
        if (ser_clr_i) begin
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                ser_c_d = ser_maj;
                carry_d = 1'b0;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                carry_d = ser_maj;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ser_c_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ser_c_q <= ser_c_d;
            done_q  <= done_d;
        end
    end

    assign s_q_o      = sum_q;
    assign c_q_o      = cout_q;
    assign ser_c_o    = ser_c_q;
    assign ser_done_o = done_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder (WIDTH=4): combinational sweep, registered copy,
// serial words, clear/hold priority and asynchronous reset.
module tb_full_adder;

    logic clk_i = 1'b0;
    logic clk_run = 1'b0;
    logic rst_ni, a_i, b_i, c_i, en_i, ser_clr_i;
    logic s_o, c_o, s_q_o, c_q_o, ser_s_o, ser_c_o, ser_done_o;

    int checks = 0;
    int failures = 0;

    full_adder #(.WIDTH(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .a_i        (a_i),
        .b_i        (b_i),
        .c_i        (c_i),
        .s_o        (s_o),
        .c_o        (c_o),
        .en_i       (en_i),
        .ser_clr_i  (ser_clr_i),
        .s_q_o      (s_q_o),
        .c_q_o      (c_q_o),
        .ser_s_o    (ser_s_o),
        .ser_c_o    (ser_c_o),
        .ser_done_o (ser_done_o)
    );

    always begin
        #5;
        if (clk_run) clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Apply one serial bit, check the sum before the edge and done after it.
    task automatic ser_bit(input string tag, input logic a, input logic b,
                           input logic exp_s, input logic exp_done);
        a_i = a;
        b_i = b;
        en_i = 1'b1;
        #1;
        check({tag, "_s"}, ser_s_o, exp_s);
        tick();
        check({tag, "_done"}, ser_done_o, exp_done);
    endtask

    logic [2:0] vec;
    logic [1:0] exp_tab [8];

    initial begin
        exp_tab[0] = 2'b00; exp_tab[1] = 2'b01; exp_tab[2] = 2'b01; exp_tab[3] = 2'b10;
        exp_tab[4] = 2'b01; exp_tab[5] = 2'b10; exp_tab[6] = 2'b10; exp_tab[7] = 2'b11;

        rst_ni = 1'b0; a_i = 1'b0; b_i = 1'b0; c_i = 1'b0; en_i = 1'b0; ser_clr_i = 1'b0;
        #1;
        check("rst_s_q", s_q_o, 1'b0);
        check("rst_c_q", c_q_o, 1'b0);
        check("rst_ser_c", ser_c_o, 1'b0);
        check("rst_done", ser_done_o, 1'b0);

        // Combinational sweep with the clock stopped.
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {a_i, b_i, c_i} = vec;
            #1;
            check($sformatf("comb_s_%0d", i), s_o, exp_tab[i][0]);
            check($sformatf("comb_c_%0d", i), c_o, exp_tab[i][1]);
            #49;
        end

        a_i = 1'b0; b_i = 1'b0; c_i = 1'b0;
        rst_ni = 1'b1;
        #2;
        clk_run = 1'b1;

        // Registered copy, then hold with en_i low.
        a_i = 1'b1; b_i = 1'b1; c_i = 1'b0; en_i = 1'b1;
        tick();
        check("reg_s_q", s_q_o, 1'b0);
        check("reg_c_q", c_q_o, 1'b1);
        en_i = 1'b0; a_i = 1'b0;
        tick();
        check("hold_s_q", s_q_o, 1'b0);
        check("hold_c_q", c_q_o, 1'b1);
        check("hold_done", ser_done_o, 1'b0);
        ser_clr_i = 1'b1;
        tick();
        ser_clr_i = 1'b0;

        // 0xB + 0x6 = 0x11
        ser_bit("b6_0", 1'b1, 1'b0, 1'b1, 1'b0);
        ser_bit("b6_1", 1'b1, 1'b1, 1'b0, 1'b0);
        ser_bit("b6_2", 1'b0, 1'b1, 1'b0, 1'b0);
        ser_bit("b6_3", 1'b1, 1'b0, 1'b0, 1'b1);
        check("b6_cout", ser_c_o, 1'b1);

        // Back-to-back: 0xF + 0x1, then 0x0 + 0x0
        ser_bit("f1_0", 1'b1, 1'b1, 1'b0, 1'b0);
        ser_bit("f1_1", 1'b1, 1'b0, 1'b0, 1'b0);
        ser_bit("f1_2", 1'b1, 1'b0, 1'b0, 1'b0);
        ser_bit("f1_3", 1'b1, 1'b0, 1'b0, 1'b1);
        check("f1_cout", ser_c_o, 1'b1);
        ser_bit("z_0", 1'b0, 1'b0, 1'b0, 1'b0);
        ser_bit("z_1", 1'b0, 1'b0, 1'b0, 1'b0);
        ser_bit("z_2", 1'b0, 1'b0, 1'b0, 1'b0);
        ser_bit("z_3", 1'b0, 1'b0, 1'b0, 1'b1);
        check("z_cout", ser_c_o, 1'b0);
        en_i = 1'b0;
        tick();
        check("z_done_pulse", ser_done_o, 1'b0);

        // Hold mid-word: carry is 1 after two bits of 1+1.
        ser_bit("h_0", 1'b1, 1'b1, 1'b0, 1'b0);
        ser_bit("h_1", 1'b1, 1'b1, 1'b1, 1'b0);
        en_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_i = k[0]; b_i = ~k[0];
            tick();
            check($sformatf("h_idle_done_%0d", k), ser_done_o, 1'b0);
        end
        ser_bit("h_2", 1'b0, 1'b0, 1'b1, 1'b0);
        ser_bit("h_3", 1'b0, 1'b0, 1'b0, 1'b1);
        check("h_cout", ser_c_o, 1'b0);

        // Clear with enable mid-word.
        ser_bit("c_0", 1'b1, 1'b1, 1'b0, 1'b0);
        ser_bit("c_1", 1'b1, 1'b1, 1'b1, 1'b0);
        a_i = 1'b1; b_i = 1'b1; c_i = 1'b0; en_i = 1'b1; ser_clr_i = 1'b1;
        tick();
        ser_clr_i = 1'b0;
        check("clr_done", ser_done_o, 1'b0);
        check("clr_ser_c_hold", ser_c_o, 1'b0);
        check("clr_c_q", c_q_o, 1'b1);
        ser_bit("c_2", 1'b1, 1'b1, 1'b0, 1'b0);
        ser_bit("c_3", 1'b1, 1'b0, 1'b0, 1'b0);
        ser_bit("c_4", 1'b1, 1'b0, 1'b0, 1'b0);
        ser_bit("c_5", 1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_cout", ser_c_o, 1'b1);

        // Asynchronous reset mid-word, between edges.
        ser_bit("r_0", 1'b1, 1'b1, 1'b0, 1'b0);
        check("r_pre_c_q", c_q_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_s_q", s_q_o, 1'b0);
        check("ar_c_q", c_q_o, 1'b0);
        check("ar_ser_c", ser_c_o, 1'b0);
        check("ar_done", ser_done_o, 1'b0);
        check("ar_ser_s", ser_s_o, 1'b0);
        a_i = 1'b1; b_i = 1'b0; c_i = 1'b1;
        #1;
        check("ar_comb_s", s_o, 1'b0);
        check("ar_comb_c", c_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        c_i = 1'b0;
        #1;
        // 0x1 + 0x1 = 0x2, full four bits because the partial word was discarded.
        ser_bit("p_0", 1'b1, 1'b1, 1'b0, 1'b0);
        ser_bit("p_1", 1'b0, 1'b0, 1'b1, 1'b0);
        ser_bit("p_2", 1'b0, 1'b0, 1'b0, 1'b0);
        ser_bit("p_3", 1'b0, 1'b0, 1'b0, 1'b1);
        check("p_cout", ser_c_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/full_adder.md
# full_adder

Single-bit full adder with a purely combinational sum/carry path, plus an optional clocked layer: a registered copy of the combinational result and a bit-serial word adder built around the same cell. The combinational path is the primitive used inside counter/adder datapaths. The clocked layer lets the same block add WIDTH-bit operands LSB-first, one bit per enabled cycle.

## Interface
- WIDTH, default 4: bits per serial word; legal range 1..32.
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- a_i  input  1  operand bit A.
- b_i  input  1  operand bit B.
- c_i  input  1  carry-in for the combinational path.
- s_o  output  1  combinational sum, a_i ^ b_i ^ c_i.
- c_o  output  1  combinational carry-out, majority(a_i, b_i, c_i).
- en_i  input  1  clock enable for registered and serial state.
- ser_clr_i  input  1  synchronous clear of serial state; priority over en_i.
- s_q_o  output  1  registered s_o.
- c_q_o  output  1  registered c_o.
- ser_s_o  output  1  combinational serial sum bit, a_i ^ b_i ^ carry_q.
- ser_c_o  output  1  registered final carry-out of the last completed serial word.
- ser_done_o  output  1  one-cycle pulse: serial word completed.

## Operation
- Combinational path: {c_o, s_o} = a_i + b_i + c_i (2-bit result). No dependency on clk_i, rst_ni or en_i; outputs are never X for known inputs.
- Truth table ({a,b,c} -> {c_o,s_o}):
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- Registered copy: on a rising edge with en_i=1, s_q_o<=s_o and c_q_o<=c_o. With en_i=0, both hold.
- Serial adder state:
  - carry_q (1 bit, internal).
  - bit counter cnt, $clog2(WIDTH) bits, minimum 1.
  - ser_c_o and ser_done_o (registered outputs).
- ser_clr_i=1 at an edge:
  - carry_q<=0, cnt<=0, ser_done_o<=0; ser_c_o holds.
  - No bit is consumed.
  - s_q_o/c_q_o still follow en_i.
- en_i=1, ser_clr_i=0 at an edge (one bit consumed):
  - If cnt<WIDTH-1: carry_q<=majority(a_i,b_i,carry_q); cnt<=cnt+1; ser_done_o<=0.
  - If cnt==WIDTH-1 (last bit): ser_c_o<=majority(a_i,b_i,carry_q); carry_q<=0; cnt<=0; ser_done_o<=1.
- en_i=0, ser_clr_i=0 at an edge: serial state holds; ser_done_o<=0.
- c_i does not feed the serial adder; the serial word carry-in is always 0.

## Timing
- s_o, c_o, ser_s_o: zero-cycle combinational, settled within 1 ns of an input change at the target corner.
- s_q_o, c_q_o: one-cycle latency from the enabled edge.
- Serial word:
  - WIDTH enabled cycles, LSB first.
  - Sample ser_s_o before each enabled edge.
  - ser_done_o and ser_c_o update at the WIDTH-th enabled edge.
  - ser_done_o is high for exactly one cycle, unless the following edge is also a completing edge (WIDTH=1 with en_i held high): it then stays high, one completion per cycle.
  - A new word can begin on the cycle after completion (no bubble).
- Reset (rst_ni=0, asynchronous, immediate):
  - s_q_o=0, c_q_o=0, ser_c_o=0, ser_done_o=0, carry_q=0, cnt=0.
  - Combinational outputs keep tracking inputs.
  - Reset asserted mid-word discards the partial word.
  - Release is synchronised by the integrator; the first edge after release behaves as a normal edge.

## Test plan
- Exhaustive combinational sweep, no clock toggling: apply {a,b,c} = 000..111 in order, 50 ns apart, check 1 ns after each change. Required {c_o,s_o}: 00, 01, 01, 10, 01, 10, 10, 11.
- Registered copy: a=1, b=1, c=0, en_i=1, one edge -> s_q_o=0, c_q_o=1. Then en_i=0 with a=0 -> outputs hold.
- Serial add, WIDTH=4: 0xB + 0x6, fed as A bits 1,1,0,1 and B bits 0,1,1,0, en_i=1.
  - ser_s_o sequence 1,0,0,0.
  - ser_c_o=1 and ser_done_o=1 after the 4th edge.
- Serial back-to-back, WIDTH=4: 0xF + 0x1, then 0x0 + 0x0 immediately.
  - First word: sum bits 0,0,0,0, ser_c_o=1.
  - Second word: sum bits 0,0,0,0, ser_c_o=0, carry_q starts at 0.
  - ser_done_o is a single-cycle pulse after each word.
- Clear/hold priority:
  - Mid-word ser_clr_i=1 together with en_i=1 -> cnt=0, carry_q=0, no bit consumed.
  - en_i=0 for 3 cycles mid-word -> serial state unchanged.
- Async reset: assert rst_ni=0 between edges mid-word -> all registered outputs 0 immediately. s_o/c_o still follow a_i/b_i/c_i.
